digit_serial_adder: RTL and testbench

- Sequential 2-bit-per-cycle adder that sums two WIDTH-bit partial-product words of the 64x64 Urdhva-Tiryagbhyam multiplier.
- Sits directly downstream of the 2-bit slice adder: it reuses that slice function every cycle, registers the inter-slice carry, and shifts the result into a WIDTH-bit sum register.
- Trades area for latency: one shared slice adder replaces a WIDTH-bit ripple chain.

---
 rtl/digit_serial_adder_pkg.sv | 18 +
 rtl/digit_serial_adder_if.sv | 39 +++
 rtl/slice_adder_2bit.sv | 12 +
 rtl/digit_serial_adder.sv | 125 ++++++++++++
 tb/tb_digit_serial_adder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/digit_serial_adder_pkg.sv
// Shared types and constants for the digit-serial adder.
// Optional feature macro: DIGIT_SERIAL_ADDER_OVF_EN.
package digit_serial_adder_pkg;

  localparam int DIGIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width clog2(width/2), kept at least 1 bit for width=2.
  function automatic int cnt_w(input int width);
    return (width / 2 > 1) ? $clog2(width / 2) : 1;
  endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Request/result bundle of the digit-serial adder.
// OVF exists only with DIGIT_SERIAL_ADDER_OVF_EN defined.
interface digit_serial_adder_if #(
  parameter int WIDTH = 64
);

  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic             OVF;

  modport master (
    output START, A, B, CIN,
    input  BUSY, DONE, SUM, COUT, OVF
  );

  modport slave (
    input  START, A, B, CIN,
    output BUSY, DONE, SUM, COUT, OVF
  );
`else
  modport master (
    output START, A, B, CIN,
    input  BUSY, DONE, SUM, COUT
  );

  modport slave (
    input  START, A, B, CIN,
    output BUSY, DONE, SUM, COUT
  );
`endif

endinterface

// File: rtl/slice_adder_2bit.sv
// Combinational 2-bit + 2-bit + carry-in slice adder.
module slice_adder_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {2'b00, cin};

endmodule

// File: rtl/digit_serial_adder.sv
// Two-bit-per-cycle adder reusing one slice adder over WIDTH/2 cycles.
// Optional signed-overflow output via DIGIT_SERIAL_ADDER_OVF_EN.
module digit_serial_adder #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 2
) (
  input  logic               CLK,
  input  logic               RST,
  digit_serial_adder_if.slave bus
);

  import digit_serial_adder_pkg::*;

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH / 2 - 1);

  if (DIGIT != digit_serial_adder_pkg::DIGIT) begin : g_bad_digit
    $error("digit_serial_adder: DIGIT must be 2");
  end

  if ((WIDTH < 2) || (WIDTH % 2 != 0)) begin : g_bad_width
    $error("digit_serial_adder: WIDTH must be even and >= 2");
  end

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry;
  logic             cout_q;
  logic [1:0]       s;
  logic             co;
  logic             last;
  logic             accept;

  assign last   = (cnt == LAST);
  assign accept = (state == ST_IDLE) && bus.START;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.START) state_nxt = ST_RUN;
      ST_RUN:  if (last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.BUSY = (state == ST_RUN);
  assign bus.DONE = (state == ST_DONE);

  slice_adder_2bit u_slice (
    .a    (a_sh[1:0]),
    .b    (b_sh[1:0]),
    .cin  (carry),
    .s    (s),
    .cout (co)
  );

  // New slice enters at the top; after WIDTH/2 steps it sits in place.
  always_comb begin
    sum_nxt = sum_q >> DIGIT;
    sum_nxt[WIDTH-1 -: 2] = s;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh  <= bus.A;
      b_sh  <= bus.B;
      carry <= bus.CIN;
      sum_q <= '0;
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      carry <= co;
      sum_q <= sum_nxt;
      cnt   <= cnt + CNT_W'(1);
      if (last) cout_q <= co;
    end
  end

  assign bus.SUM  = sum_q;
  assign bus.COUT = cout_q;

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a_msb <= bus.A[WIDTH-1];
      b_msb <= bus.B[WIDTH-1];
    end else if ((state == ST_RUN) && last) begin
      ovf_q <= (a_msb == b_msb) && (s[1] != a_msb);
    end
  end

  assign bus.OVF = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder (WIDTH=64).
// Checks OVF too when DIGIT_SERIAL_ADDER_OVF_EN is defined.
module tb_digit_serial_adder;

  localparam int W = 64;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t sb[$];
  exp_t last_exp;

  digit_serial_adder_if #(.WIDTH(W)) bus ();

  digit_serial_adder #(.WIDTH(W), .DIGIT(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [64:0] act,
                     input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic c);
    logic [W:0] t;
    exp_t e;
    t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return e;
  endfunction

  // Steps negedges after an accepting edge until DONE; lat<0 on timeout.
  task automatic wait_done(input int n0, output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int i = n0 + 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.BUSY) bc++;
      if (bus.DONE) begin
        lat = i;
        return;
      end
    end
    $display("FAIL done_timeout no DONE within 100 cycles");
  endtask

  task automatic check_result();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty DONE with no pending result");
    end else begin
      e = sb.pop_front();
      last_exp = e;
      chk("sum", bus.SUM, {1'b0, e.sum});
      chk("cout", bus.COUT, {64'd0, e.cout});
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      chk("ovf", bus.OVF, {64'd0, e.ovf});
`endif
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input exp_t e);
    @(negedge clk);
    bus.START = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.CIN = c;
    @(posedge clk);
    sb.push_back(e);
    #1;
    bus.START = 1'b0;
    bus.A = {$urandom, $urandom};
    bus.B = {$urandom, $urandom};
    bus.CIN = 1'($urandom);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input exp_t e);
    int lat;
    int bc;
    start_op(a, b, c, e);
    wait_done(0, lat, bc);
    chk("latency", 65'(lat), 65'd33);
    chk("busy_cycles", 65'(bc), 65'd32);
    check_result();
    repeat (2) @(negedge clk);
    chk("done_pulse", {64'd0, bus.DONE}, 65'd0);
    chk("sum_held", {1'b0, bus.SUM}, {1'b0, last_exp.sum});
    chk("cout_held", {64'd0, bus.COUT}, {64'd0, last_exp.cout});
  endtask

  initial begin
    vec_t tbl[9];
    exp_t e;
    int lat;
    int bc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;

    total = 0;
    bad = 0;

    tbl[0] = '{64'h5, 64'h3, 1'b0, 64'h8, 1'b0, 1'b0};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
               64'h0, 1'b1, 1'b0};
    tbl[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    tbl[4] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0};
    tbl[5] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0};
    tbl[6] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    tbl[7] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1,
               64'h0, 1'b1, 1'b0};
    tbl[8] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
               64'h0, 1'b1, 1'b1};

    rst = 1'b1;
    bus.START = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.CIN = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {64'd0, bus.BUSY}, 65'd0);
    chk("rst_done", {64'd0, bus.DONE}, 65'd0);
    chk("rst_sum", {1'b0, bus.SUM}, 65'd0);
    chk("rst_cout", {64'd0, bus.COUT}, 65'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      e.sum  = tbl[i].sum;
      e.cout = tbl[i].cout;
      e.ovf  = tbl[i].ovf;
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, e);
    end

    // START during RUN is ignored; held START restarts from IDLE.
    start_op(64'd123, 64'd456, 1'b0, '{64'd579, 1'b0, 1'b0});
    repeat (10) @(negedge clk);
    bus.START = 1'b1;
    bus.A = 64'hFFFF_0000_FFFF_0000;
    bus.B = 64'h0001_0000_0000_0000;
    bus.CIN = 1'b1;
    wait_done(10, lat, bc);
    chk("busy_start_latency", 65'(lat), 65'd33);
    check_result();
    @(posedge clk);
    @(posedge clk);
    sb.push_back(model(64'hFFFF_0000_FFFF_0000,
                       64'h0001_0000_0000_0000, 1'b1));
    #1;
    bus.START = 1'b0;
    wait_done(0, lat, bc);
    chk("restart_latency", 65'(lat), 65'd33);
    check_result();

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    bus.START = 1'b1;
    bus.A = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.B = 64'h2;
    bus.CIN = 1'b0;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    repeat (16) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {64'd0, bus.BUSY}, 65'd0);
    chk("abort_done", {64'd0, bus.DONE}, 65'd0);
    chk("abort_sum", {1'b0, bus.SUM}, 65'd0);
    chk("abort_cout", {64'd0, bus.COUT}, 65'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", {64'd0, bus.DONE}, 65'd0);
    end
    rst = 1'b0;
    run_op(64'd9, 64'd10, 1'b1, '{64'd20, 1'b0, 1'b0});

    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      run_op(ra, rb, rc, model(ra, rb, rc));
    end

    chk("sb_drained", 65'(sb.size()), 65'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
